// File: rtl/regmodel0_regmodel_core_reg_intf_pkg.sv
// regmodel0_regmodel_core_reg_intf_pkg: shared widths, FSM states and response status codes
// for the register-model core interface.
package regmodel0_regmodel_core_reg_intf_pkg;
    localparam int PAYLOAD_W = 34;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_RESET  = 2'd3
    } state_e;
    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_SLVERR  = 2'b01;
    localparam logic [1:0] STS_TIMEOUT = 2'b10;
    localparam logic [1:0] STS_DECERR  = 2'b11;
endpackage

// File: rtl/regmodel0_regmodel_core_reg_intf_reqctl_tmo.sv
// regmodel0_regmodel_core_reg_intf_reqctl_tmo: 8-bit access timeout counter; expired flags
// the last permitted ACCESS cycle.
module regmodel0_regmodel_core_reg_intf_reqctl_tmo #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic payload_cgm_clk,
    input  logic hw_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] count;
    always_ff @(posedge payload_cgm_clk or negedge hw_reset_n)
        if (!hw_reset_n) count <= '0;
        else count <= clear ? '0 : enable ? count + 8'd1 : count;
    assign expired = count == LAST;
endmodule

// File: rtl/regmodel0_regmodel_core_reg_intf_reqctl.sv
// regmodel0_regmodel_core_reg_intf_reqctl: single-outstanding request controller driving the
// register-file access port and producing {status, rdata} responses for the skid buffer.
module regmodel0_regmodel_core_reg_intf_reqctl
    import regmodel0_regmodel_core_reg_intf_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 16'h1000
) (
    input  logic                 payload_cgm_clk,
    input  logic                 hw_reset_n,
    input  logic                 func_reset_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [DATA_W-1:0]    req_wdata_i,
    output logic                 acc_valid_o,
    output logic                 acc_write_o,
    output logic [ADDR_W-1:0]    acc_addr_o,
    output logic [DATA_W-1:0]    acc_wdata_o,
    input  logic                 acc_ack_i,
    input  logic [DATA_W-1:0]    acc_rdata_i,
    input  logic                 acc_err_i,
    output logic                 resp_valid_o,
    output logic [PAYLOAD_W-1:0] resp_payload_o,
    input  logic                 resp_ready_i,
    output logic                 stray_ack_o
);
    state_e state;
    logic expired;
    regmodel0_regmodel_core_reg_intf_reqctl_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .payload_cgm_clk(payload_cgm_clk),
        .hw_reset_n(hw_reset_n),
        .clear(state != ST_ACCESS),
        .enable(state == ST_ACCESS),
        .expired(expired)
    );
    // Handshake strobes are pure state decodes, so no input reaches an output combinationally.
    assign req_ready_o = state == ST_IDLE;
    assign acc_valid_o = state == ST_ACCESS;
    assign resp_valid_o = state == ST_RESP;
    always_ff @(posedge payload_cgm_clk or negedge hw_reset_n)
        if (!hw_reset_n) begin
            state <= ST_RESET;
            acc_write_o <= 1'b0;
            acc_addr_o <= '0;
            acc_wdata_o <= '0;
            resp_payload_o <= '0;
            stray_ack_o <= 1'b0;
        end else if (!func_reset_n) begin
            state <= ST_RESET;
            acc_write_o <= 1'b0;
            acc_addr_o <= '0;
            acc_wdata_o <= '0;
            resp_payload_o <= '0;
            stray_ack_o <= 1'b0;
        end else begin
            if (acc_ack_i && state != ST_ACCESS) stray_ack_o <= 1'b1;
            case (state)
                ST_RESET: state <= ST_IDLE;
                ST_IDLE:
                    if (req_valid_i) begin
                        acc_write_o <= req_write_i;
                        acc_addr_o <= req_addr_i;
                        acc_wdata_o <= req_wdata_i;
                        state <= req_addr_i >= ADDR_LIMIT ? ST_RESP : ST_ACCESS;
                        if (req_addr_i >= ADDR_LIMIT) resp_payload_o <= {STS_DECERR, {DATA_W{1'b0}}};
                    end
                ST_ACCESS:
                    if (acc_ack_i) begin
                        state <= ST_RESP;
                        resp_payload_o <= {acc_err_i ? STS_SLVERR : STS_OK,
                                           (!acc_write_o && !acc_err_i) ? acc_rdata_i : {DATA_W{1'b0}}};
                    end else if (expired) begin
                        state <= ST_RESP;
                        resp_payload_o <= {STS_TIMEOUT, {DATA_W{1'b0}}};
                    end
                ST_RESP: if (resp_ready_i) state <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_regmodel0_regmodel_core_reg_intf_reqctl.sv
// tb_regmodel0_regmodel_core_reg_intf_reqctl: directed and randomized transactions checked
// against a transaction-level model of the request controller.
module tb_regmodel0_regmodel_core_reg_intf_reqctl;
    localparam int TMO = 4;
    logic clk = 1'b0, hw_reset_n = 1'b0, func_reset_n = 1'b1;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic acc_valid, acc_write, acc_ack = 1'b0, acc_err = 1'b0;
    logic [15:0] acc_addr;
    logic [31:0] acc_wdata, acc_rdata = '0;
    logic resp_valid, resp_ready = 1'b0, stray_ack;
    logic [33:0] resp_payload;
    int checks = 0, errors = 0;

    regmodel0_regmodel_core_reg_intf_reqctl #(.TIMEOUT_CYCLES(TMO), .ADDR_LIMIT(16'h1000)) dut (
        .payload_cgm_clk(clk), .hw_reset_n(hw_reset_n), .func_reset_n(func_reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .acc_valid_o(acc_valid), .acc_write_o(acc_write), .acc_addr_o(acc_addr),
        .acc_wdata_o(acc_wdata), .acc_ack_i(acc_ack), .acc_rdata_i(acc_rdata), .acc_err_i(acc_err),
        .resp_valid_o(resp_valid), .resp_payload_o(resp_payload), .resp_ready_i(resp_ready),
        .stray_ack_o(stray_ack)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [86:0] all_outs();
        return {req_ready, acc_valid, acc_write, acc_addr, acc_wdata, resp_valid, resp_payload, stray_ack};
    endfunction

    // ack_delay: ACCESS cycles that pass before the ack cycle; >= TMO means never ack.
    task automatic run_txn(input string name, input logic w, input logic [15:0] a, input logic [31:0] wd,
                           input int ack_delay, input logic err, input logic [31:0] rd, input int hold);
        logic dec;
        logic [1:0] st;
        logic [33:0] exp_pl;
        int exp_cyc, cyc;
        dec = a >= 16'h1000;
        exp_cyc = dec ? 0 : (ack_delay < TMO ? ack_delay + 1 : TMO);
        st = dec ? 2'b11 : (ack_delay < TMO ? {1'b0, err} : 2'b10);
        exp_pl = {st, (st == 2'b00 && !w) ? rd : 32'h0};
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready got %b want 1", name, req_ready); end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
        cyc = 0;
        while (acc_valid === 1'b1 && cyc < 300) begin
            cyc++;
            if (cyc == 1) begin
                checks++;
                if ({acc_write, acc_addr, acc_wdata} !== {w, a, wd}) begin
                    errors++;
                    $display("FAIL %s acc_bus got %b/%h/%h want %b/%h/%h", name, acc_write, acc_addr, acc_wdata, w, a, wd);
                end
            end
            if (ack_delay < TMO && cyc == ack_delay + 1) begin acc_ack = 1'b1; acc_err = err; acc_rdata = rd; end
            step();
            acc_ack = 1'b0; acc_err = 1'($urandom); acc_rdata = $urandom;
        end
        checks++;
        if (cyc != exp_cyc) begin errors++; $display("FAIL %s acc_cycles got %0d want %0d", name, cyc, exp_cyc); end
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL %s resp_valid got %b want 1", name, resp_valid); end
        checks++;
        if (resp_payload !== exp_pl) begin errors++; $display("FAIL %s payload got %h want %h", name, resp_payload, exp_pl); end
        for (int i = 0; i < hold; i++) begin
            step();
            checks++;
            if ({resp_valid, req_ready, resp_payload} !== {2'b10, exp_pl}) begin
                errors++;
                $display("FAIL %s hold%0d valid/ready/payload got %b/%b/%h want 1/0/%h", name, i, resp_valid, req_ready, resp_payload, exp_pl);
            end
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s post_handshake valid/ready got %b/%b want 0/1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", all_outs()); end
        hw_reset_n = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL reset_hold got %h want 0", all_outs()); end
        step();
        checks++;
        if ({req_ready, acc_valid, resp_valid} !== 3'b100) begin
            errors++; $display("FAIL reset_to_idle got %b want 100", {req_ready, acc_valid, resp_valid});
        end
    endtask

    task automatic test_directed();
        run_txn("read_ok", 1'b0, 16'h0010, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);
        run_txn("write_slverr", 1'b1, 16'h0020, 32'h12345678, 0, 1'b1, 32'hCAFEF00D, 0);
        run_txn("decerr", 1'b0, 16'h1000, 32'h0, 0, 1'b0, 32'h11111111, 0);
        run_txn("timeout", 1'b0, 16'h0FFF, 32'h0, TMO, 1'b0, 32'h0, 0);
        run_txn("ack_on_last", 1'b0, 16'h0030, 32'h0, TMO - 1, 1'b0, 32'hA5A5A5A5, 0);
        run_txn("backpressure", 1'b0, 16'h0044, 32'h0, 1, 1'b0, 32'h5A5A1234, 5);
    endtask

    task automatic test_func_reset();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (acc_valid !== 1'b1) begin errors++; $display("FAIL freset_in_access got %b want 1", acc_valid); end
        func_reset_n = 1'b0;
        step();
        func_reset_n = 1'b1;
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL freset_outs got %h want 0", all_outs()); end
        step();
        checks++;
        if ({req_ready, acc_valid, resp_valid} !== 3'b100) begin
            errors++; $display("FAIL freset_idle got %b want 100", {req_ready, acc_valid, resp_valid});
        end
        step(); step();
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL freset_no_resp got %b want 0", resp_valid); end
        req_valid = 1'b1; req_addr = 16'hF000;
        step();
        req_valid = 1'b0;
        func_reset_n = 1'b0;
        step();
        func_reset_n = 1'b1;
        checks++;
        if ({resp_valid, resp_payload} !== 35'h0) begin
            errors++; $display("FAIL freset_resp got %b/%h want 0/0", resp_valid, resp_payload);
        end
        step();
    endtask

    task automatic test_stray_ack();
        checks++;
        if (stray_ack !== 1'b0) begin errors++; $display("FAIL stray_before got %b want 0", stray_ack); end
        acc_ack = 1'b1;
        step();
        acc_ack = 1'b0;
        checks++;
        if (stray_ack !== 1'b1) begin errors++; $display("FAIL stray_set got %b want 1", stray_ack); end
        run_txn("after_stray", 1'b0, 16'h0050, 32'h0, 0, 1'b0, 32'h00C0FFEE, 1);
        checks++;
        if (stray_ack !== 1'b1) begin errors++; $display("FAIL stray_sticky got %b want 1", stray_ack); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h1000, 16'hFFFF)) : 16'($urandom_range(0, 16'h0FFF));
            run_txn($sformatf("rand%0d", n), 1'($urandom), a, $urandom, $urandom_range(0, TMO + 1),
                    1'($urandom), $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_func_reset();
        test_stray_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/regmodel0_regmodel_core_reg_intf_reqctl.md
# regmodel0_regmodel_core_reg_intf_reqctl

Request controller for the register-model core interface. It accepts one register read or write request at a time and drives it onto the register-file access port. It waits for an acknowledge, bounded by a timeout, then formats the 34-bit response payload ({status, rdata}). It sits directly upstream of the response skid buffer and feeds that buffer's valid/payload/ready input.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without ack before a timeout response; legal range 2..255.
- ADDR_LIMIT, 16'h1000: word addresses >= this value are decode errors.
- payload_cgm_clk  in  1  clock.
- hw_reset_n  in  1  reset, asynchronous, active-low.
- func_reset_n  in  1  synchronous functional reset, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  16  word address.
- req_wdata_i  in  32  write data.
- acc_valid_o  out  1  register access strobe, held until ack or timeout.
- acc_write_o  out  1  registered copy of req_write_i.
- acc_addr_o  out  16  registered address.
- acc_wdata_o  out  32  registered write data.
- acc_ack_i  in  1  access complete, single-cycle pulse.
- acc_rdata_i  in  32  read data, valid with acc_ack_i.
- acc_err_i  in  1  slave error, valid with acc_ack_i.
- resp_valid_o  out  1  response valid, to respbuf valid_i.
- resp_payload_o  out  34  [33:32] status, [31:0] rdata, to respbuf payload_i.
- resp_ready_i  in  1  from respbuf ready_o.
- stray_ack_o  out  1  sticky flag: acc_ack_i seen outside ACCESS; cleared only by reset.

## Operation
- State encoding:
  - RESET = 2'd3
  - IDLE = 2'd0
  - ACCESS = 2'd1
  - RESP = 2'd2
- RESET -> IDLE, unconditionally, after one cycle.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, capture write/addr/wdata.
  - If addr >= ADDR_LIMIT, go to RESP with status 2'b11, rdata 0.
  - Otherwise go to ACCESS; timeout counter cleared to 0.
- ACCESS:
  - acc_valid_o = 1.
  - On acc_ack_i, go to RESP:
    - status = acc_err_i ? 2'b01 : 2'b00.
    - rdata = (read && !acc_err_i) ? acc_rdata_i : 0.
  - Else if counter == TIMEOUT_CYCLES-1, go to RESP with status 2'b10, rdata 0.
  - Else counter increments.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - resp_valid_o = 1; resp_payload_o comes from registers and is stable while valid.
  - On resp_ready_i, go to IDLE.
- Status codes:
  - 00 OK
  - 01 SLVERR
  - 10 TIMEOUT
  - 11 DECERR
- Write responses always carry rdata = 0.
- acc_ack_i in any state other than ACCESS: ignored for data, sets stray_ack_o.

## Timing
- Reset:
  - hw_reset_n low asynchronously forces state RESET.
  - func_reset_n low at a clock edge also forces state RESET.
  - All outputs are 0 in RESET, including req_ready_o, acc_valid_o, resp_valid_o, resp_payload_o and the acc_* buses.
  - stray_ack_o resets to 0.
- Minimum latency:
  - Request accepted at edge 0.
  - acc_valid_o high in cycle 1.
  - Ack in cycle 1 gives resp_valid_o in cycle 2.
  - Request-to-response minimum is 2 cycles.
- Decode error: resp_valid_o in the cycle after acceptance; acc_valid_o never asserts.
- Timeout: acc_valid_o is high for exactly TIMEOUT_CYCLES cycles; resp_valid_o follows in the next cycle.
- Handshake:
  - At most one outstanding request.
  - req_ready_o is 0 in ACCESS and RESP.
  - No new request is accepted in the cycle the response handshakes; IDLE comes the next cycle.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- func_reset_n low mid-ACCESS or mid-RESP:
  - The transaction is aborted and no response is produced.
  - acc_valid_o and resp_valid_o drop at that edge.

## Structure
- Shared package regmodel0_regmodel_core_reg_intf_pkg holds:
  - state encoding constants
  - status codes
  - PAYLOAD_W = 34, DATA_W = 32, ADDR_W = 16
- One natural sub-module: regmodel0_regmodel_core_reg_intf_reqctl_tmo, the 8-bit timeout counter.
  - Inputs: clear, enable.
  - Output: expired, high when count == TIMEOUT_CYCLES-1.
- Everything else is one FSM and the capture registers in the top module.

## Test plan
- Read, addr 16'h0010, ack after 3 cycles with rdata 32'hDEADBEEF, err 0 -> acc_valid_o high 3 cycles; payload 34'h0_DEADBEEF.
- Write, addr 16'h0020, wdata 32'h12345678, ack with err 1 -> acc_wdata_o = 32'h12345678; payload {2'b01, 32'h0}.
- Read, addr 16'h1000 -> no acc_valid_o; resp_valid_o one cycle after acceptance; payload {2'b11, 32'h0}.
- No ack, TIMEOUT_CYCLES = 4 -> acc_valid_o high exactly 4 cycles; payload {2'b10, 32'h0}.
- Then ack exactly on the 4th cycle -> OK response, not timeout.
- resp_ready_i held low 5 cycles -> payload stable, req_ready_o = 0 throughout.
- Pulse func_reset_n low mid-ACCESS -> no response; RESET for one cycle, then IDLE.
- A later stray acc_ack_i -> stray_ack_o = 1.
